// File: rtl/id_ex_reg_pkg.sv
// Shared MIPS pipeline package: ALU operation encodings, register index
// width and the stage-action type used by the pipeline registers.
package id_ex_reg_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_CLEAR = 2'd2
    } stage_action_e;

    // A frozen stage ignores flush; otherwise flush beats stall, stall beats load.
    function automatic stage_action_e select_action(input logic en,
                                                    input logic flush,
                                                    input logic stall);
        stage_action_e act;
        if (!en) begin
            act = ACT_HOLD;
        end else if (flush) begin
            act = ACT_CLEAR;
        end else if (stall) begin
            act = ACT_HOLD;
        end else begin
            act = ACT_LOAD;
        end
        return act;
    endfunction

endpackage

// File: rtl/id_ex_reg_pipe_field_reg.sv
// Width-parameterised pipeline field register with load, hold and clear.
module pipe_field_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Priority: reset, then clear (bubble), then hold, otherwise load d.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with debugger freeze, hazard stall/flush and a
// count of valid instructions admitted into the execute stage.
module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  EnE,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  RegWriteD,
    input  logic                  MemtoRegD,
    input  logic                  MemWriteD,
    input  logic                  ALUSrcD,
    input  logic                  RegDstD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [DATA_W-1:0]     RD1D,
    input  logic [DATA_W-1:0]     RD2D,
    input  logic [DATA_W-1:0]     SignImmD,
    input  logic [DATA_W-1:0]     PCPlus4D,
    input  logic [REG_IDX_W-1:0]  RsD,
    input  logic [REG_IDX_W-1:0]  RtD,
    input  logic [REG_IDX_W-1:0]  RdD,
    input  logic                  ValidD,
    output logic                  RegWriteE,
    output logic                  MemtoRegE,
    output logic                  MemWriteE,
    output logic                  ALUSrcE,
    output logic                  RegDstE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic [DATA_W-1:0]     RD1E,
    output logic [DATA_W-1:0]     RD2E,
    output logic [DATA_W-1:0]     SignImmE,
    output logic [DATA_W-1:0]     PCPlus4E,
    output logic [REG_IDX_W-1:0]  RsE,
    output logic [REG_IDX_W-1:0]  RtE,
    output logic [REG_IDX_W-1:0]  RdE,
    output logic                  ValidE,
    output logic [31:0]           InstrCountE
);

    localparam int CTRL_W = 6 + ALU_CTRL_W;
    localparam int DAT_W  = 4 * DATA_W;
    localparam int IDX_W  = 3 * REG_IDX_W;

    stage_action_e act;
    logic          clear;
    logic          hold;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DAT_W-1:0]  dat_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       instr_count;

    assign act   = select_action(EnE, FlushE, StallE);
    assign clear = (act == ACT_CLEAR);
    assign hold  = (act == ACT_HOLD);

    pipe_field_reg #(.W(CTRL_W)) ctrl_reg (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .hold  (hold),
        .d     ({RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD, ValidD}),
        .q     (ctrl_q)
    );

    pipe_field_reg #(.W(DAT_W)) data_reg (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .hold  (hold),
        .d     ({RD1D, RD2D, SignImmD, PCPlus4D}),
        .q     (dat_q)
    );

    pipe_field_reg #(.W(IDX_W)) idx_reg (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .hold  (hold),
        .d     ({RsD, RtD, RdD}),
        .q     (idx_q)
    );

    assign {RegWriteE, MemtoRegE, MemWriteE, ALUSrcE, RegDstE, ALUControlE, ValidE} = ctrl_q;
    assign {RD1E, RD2E, SignImmE, PCPlus4E} = dat_q;
    assign {RsE, RtE, RdE} = idx_q;
    assign InstrCountE = instr_count;

    // Count real instructions entering EX; only a genuine load advances it, wrapping silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_count <= '0;
        end else if (act == ACT_LOAD && ValidD) begin
            instr_count <= instr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus pushes expected state, a monitor
// pops and compares after every clock edge; directed spot checks use constants.
module tb_id_ex_reg;

    typedef struct packed {
        logic        RegWrite;
        logic        MemtoReg;
        logic        MemWrite;
        logic        ALUSrc;
        logic        RegDst;
        logic [2:0]  ALUControl;
        logic [31:0] RD1;
        logic [31:0] RD2;
        logic [31:0] SignImm;
        logic [31:0] PCPlus4;
        logic [4:0]  Rs;
        logic [4:0]  Rt;
        logic [4:0]  Rd;
        logic        Valid;
    } fields_t;

    typedef struct packed {
        fields_t     f;
        logic [31:0] count;
    } state_t;

    logic    clk;
    logic    reset;
    logic    EnE;
    logic    StallE;
    logic    FlushE;
    fields_t din;
    fields_t dout;
    logic [31:0] InstrCountE;
    state_t  actual;
    state_t  model;
    state_t  expq[$];
    int      nTests;
    int      nFail;

    id_ex_reg #(.DATA_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .EnE         (EnE),
        .StallE      (StallE),
        .FlushE      (FlushE),
        .RegWriteD   (din.RegWrite),
        .MemtoRegD   (din.MemtoReg),
        .MemWriteD   (din.MemWrite),
        .ALUSrcD     (din.ALUSrc),
        .RegDstD     (din.RegDst),
        .ALUControlD (din.ALUControl),
        .RD1D        (din.RD1),
        .RD2D        (din.RD2),
        .SignImmD    (din.SignImm),
        .PCPlus4D    (din.PCPlus4),
        .RsD         (din.Rs),
        .RtD         (din.Rt),
        .RdD         (din.Rd),
        .ValidD      (din.Valid),
        .RegWriteE   (dout.RegWrite),
        .MemtoRegE   (dout.MemtoReg),
        .MemWriteE   (dout.MemWrite),
        .ALUSrcE     (dout.ALUSrc),
        .RegDstE     (dout.RegDst),
        .ALUControlE (dout.ALUControl),
        .RD1E        (dout.RD1),
        .RD2E        (dout.RD2),
        .SignImmE    (dout.SignImm),
        .PCPlus4E    (dout.PCPlus4),
        .RsE         (dout.Rs),
        .RtE         (dout.Rt),
        .RdE         (dout.Rd),
        .ValidE      (dout.Valid),
        .InstrCountE (InstrCountE)
    );

    assign actual = '{f: dout, count: InstrCountE};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic fields_t mkVec(input logic [31:0] s);
        fields_t v;
        v.RegWrite   = s[0];
        v.MemtoReg   = s[1];
        v.MemWrite   = s[2];
        v.ALUSrc     = s[3];
        v.RegDst     = s[4];
        v.ALUControl = s[7:5];
        v.RD1        = 32'h1000_0000 ^ s;
        v.RD2        = ~s;
        v.SignImm    = s << 4;
        v.PCPlus4    = s + 32'd4;
        v.Rs         = s[4:0];
        v.Rt         = s[9:5];
        v.Rd         = s[14:10];
        v.Valid      = 1'b1;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Drive one vector on the falling edge, push the expected post-edge state,
    // and return shortly after the rising edge so spot checks can follow.
    task automatic applyStimulus(input fields_t d, input logic rst, input logic en,
                                 input logic stall, input logic flush);
        @(negedge clk);
        din    = d;
        reset  = rst;
        EnE    = en;
        StallE = stall;
        FlushE = flush;
        if (rst) begin
            model = '0;
        end else if (!en) begin
            model = model;
        end else if (flush) begin
            model.f = '0;
        end else if (!stall) begin
            model.f = d;
            if (d.Valid) model.count = model.count + 32'd1;
        end
        expq.push_back(model);
        @(posedge clk);
        #2;
    endtask

    // Monitor: after every rising edge, compare against the oldest expectation.
    initial begin
        state_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                exp = expq.pop_front();
                checkOutput("scoreboard", 256'(actual), 256'(exp));
            end
        end
    end

    initial begin
        fields_t a;
        fields_t v;
        nTests = 0;
        nFail  = 0;
        model  = '0;
        din    = '1;
        reset  = 1'b1;
        EnE    = 1'b1;
        StallE = 1'b1;
        FlushE = 1'b1;

        // Reset with every D input high.
        applyStimulus('1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("reset_valid", 256'(dout.Valid), 256'(0));
        checkOutput("reset_rd1", 256'(dout.RD1), 256'(0));
        checkOutput("reset_count", 256'(InstrCountE), 256'(0));

        // Basic load.
        v = mkVec(32'h0000_0055);
        v.Rt = 5'd8; v.Rd = 5'd17; v.RegDst = 1'b1; v.RD1 = 32'h0000_1234; v.Valid = 1'b1;
        applyStimulus(v, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("load_rt", 256'(dout.Rt), 256'(8));
        checkOutput("load_rd", 256'(dout.Rd), 256'(17));
        checkOutput("load_regdst", 256'(dout.RegDst), 256'(1));
        checkOutput("load_rd1", 256'(dout.RD1), 256'(32'h1234));
        checkOutput("load_count", 256'(InstrCountE), 256'(1));

        // Load A, stall three cycles with fresh D values, then flush+stall.
        a = mkVec(32'h0000_A5A5);
        a.RegWrite = 1'b1; a.MemWrite = 1'b1; a.RD1 = 32'hAAAA_0001;
        applyStimulus(a, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(mkVec(32'h0000_0100 + 32'(i)), 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkOutput("stall_rd1", 256'(dout.RD1), 256'(32'hAAAA_0001));
        checkOutput("stall_count", 256'(InstrCountE), 256'(2));
        applyStimulus(mkVec(32'h0000_0777), 1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("flush_regwrite", 256'(dout.RegWrite), 256'(0));
        checkOutput("flush_memwrite", 256'(dout.MemWrite), 256'(0));
        checkOutput("flush_valid", 256'(dout.Valid), 256'(0));
        checkOutput("flush_count", 256'(InstrCountE), 256'(2));

        // Load B, freeze with flush requested, then unfreeze into a bubble.
        v = mkVec(32'h0000_0B0B);
        v.RD1 = 32'hBBBB_0002;
        applyStimulus(v, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mkVec(32'h0000_0200 + 32'(i)), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput("freeze_rd1", 256'(dout.RD1), 256'(32'hBBBB_0002));
        checkOutput("freeze_count", 256'(InstrCountE), 256'(3));
        applyStimulus(mkVec(32'h0000_0300), 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("unfreeze_valid", 256'(dout.Valid), 256'(0));
        checkOutput("unfreeze_rd1", 256'(dout.RD1), 256'(0));

        // Invalid slot still copies control bits but does not count.
        v = mkVec(32'h0000_001F);
        v.Valid = 1'b0;
        applyStimulus(v, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("invalid_regwrite", 256'(dout.RegWrite), 256'(1));
        checkOutput("invalid_count", 256'(InstrCountE), 256'(3));

        // Counter wrap from a forced near-full value.
        @(negedge clk);
        force dut.instr_count = 32'hFFFF_FFFE;
        #1;
        release dut.instr_count;
        model.count = 32'hFFFF_FFFE;
        applyStimulus(mkVec(32'h0000_0401), 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_ff", 256'(InstrCountE), 256'(32'hFFFF_FFFF));
        v = mkVec(32'h0000_0402);
        v.Valid = 1'b0;
        applyStimulus(v, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_hold", 256'(InstrCountE), 256'(32'hFFFF_FFFF));
        applyStimulus(mkVec(32'h0000_0403), 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("wrap_zero", 256'(InstrCountE), 256'(0));

        // Reset arriving mid-stall and mid-freeze discards the held instruction.
        a = mkVec(32'h0000_0C01);
        a.RegWrite = 1'b1;
        applyStimulus(a, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(mkVec(32'h0000_0C02), 1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(mkVec(32'h0000_0C03), 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("rststall_regwrite", 256'(dout.RegWrite), 256'(0));
        checkOutput("rststall_count", 256'(InstrCountE), 256'(0));
        v = mkVec(32'h0000_0D04);
        v.RD1 = 32'hCCCC_0003;
        applyStimulus(v, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("postrst_rd1", 256'(dout.RD1), 256'(32'hCCCC_0003));
        checkOutput("postrst_count", 256'(InstrCountE), 256'(1));

        // Let the monitor drain; anything left over is a missed comparison.
        repeat (3) @(posedge clk);
        #3;
        if (expq.size() != 0) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
